// File: rtl/wb_burst_writer.sv
// Writeback stage: selects RF write data and drives the register-file write port.
// A 128-bit load is written as four 32-bit words to consecutive registers while the pipeline stalls.
module wb_burst_writer #(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter bit          ZERO_GUARD  = 1'b1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [1:0]   MemToReg_In,
  input  logic [4:0]   RegDest_In,
  input  logic         RegWrite_In,
  input  logic         L16B_In,
  input  logic [31:0]  ALUResult_In,
  input  logic [31:0]  PC_In,
  input  logic [31:0]  ReadData_In,
  input  logic [127:0] WD3_128_In,
  output logic         RF_WE,
  output logic [4:0]   RF_WA,
  output logic [31:0]  RF_WD,
  output logic         Stall_Out,
  output logic         Busy_Out,
  output logic         Overrun_Out
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_cnt;
  logic [127:0]   r_data;
  logic [4:0]     r_base;

  logic           w_accept;
  logic           w_we, w_stall, w_busy;
  logic [4:0]     w_wa;
  logic [31:0]    w_wd;
  logic [31:0]    w_sel_wd;
  logic [6:0]     w_sel;

  // Busy_Out stays high through the word-3 cycle after the FSM is back in IDLE,
  // so requests arriving then are still rejected.
  assign w_accept = (r_state == IDLE) && !Busy_Out && RegWrite_In;
  assign w_sel    = {r_cnt, 5'b0};

  always_comb begin
    w_sel_wd = ALUResult_In;
    case (MemToReg_In)
      2'b01:   w_sel_wd = ReadData_In;
      2'b10:   w_sel_wd = PC_In + LINK_OFFSET;
      default: w_sel_wd = ALUResult_In;
    endcase
  end

  // State register plus burst bookkeeping
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_data  <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        if (w_accept && L16B_In) begin
          r_cnt  <= 2'd1;
          r_data <= WD3_128_In;
          r_base <= RegDest_In;
        end
      end else begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && L16B_In) w_state_nxt = BURST;
      BURST:   if (r_cnt == 2'd3)       w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_wa    = '0;
    w_wd    = '0;
    w_stall = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_we = 1'b1;
          w_wa = RegDest_In;
          if (L16B_In) begin
            w_wd    = WD3_128_In[31:0];
            w_stall = 1'b1;
            w_busy  = 1'b1;
          end else begin
            w_wd = w_sel_wd;
          end
        end
      end
      BURST: begin
        w_we    = 1'b1;
        w_wa    = r_base + {3'b0, r_cnt};
        w_wd    = r_data[w_sel +: 32];
        w_busy  = 1'b1;
        w_stall = (r_cnt != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      RF_WE       <= 1'b0;
      RF_WA       <= '0;
      RF_WD       <= '0;
      Stall_Out   <= 1'b0;
      Busy_Out    <= 1'b0;
      Overrun_Out <= 1'b0;
    end else begin
      RF_WE       <= w_we && !(ZERO_GUARD && (w_wa == 5'd0));
      RF_WA       <= w_wa;
      RF_WD       <= w_wd;
      Stall_Out   <= w_stall;
      Busy_Out    <= w_busy;
      Overrun_Out <= Overrun_Out | (Busy_Out & RegWrite_In);
    end
  end

endmodule

// File: tb/tb_wb_burst_writer.sv
// Directed bench for wb_burst_writer: single writes, link address, R0 guard,
// 128-bit bursts with wrap, overrun and mid-burst reset.
module tb_wb_burst_writer;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [1:0]   MemToReg_In;
  logic [4:0]   RegDest_In;
  logic         RegWrite_In;
  logic         L16B_In;
  logic [31:0]  ALUResult_In;
  logic [31:0]  PC_In;
  logic [31:0]  ReadData_In;
  logic [127:0] WD3_128_In;
  logic         RF_WE;
  logic [4:0]   RF_WA;
  logic [31:0]  RF_WD;
  logic         Stall_Out;
  logic         Busy_Out;
  logic         Overrun_Out;

  int checks = 0;
  int errors = 0;

  wb_burst_writer #(.LINK_OFFSET(32'd8), .ZERO_GUARD(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .MemToReg_In(MemToReg_In), .RegDest_In(RegDest_In),
    .RegWrite_In(RegWrite_In), .L16B_In(L16B_In), .ALUResult_In(ALUResult_In),
    .PC_In(PC_In), .ReadData_In(ReadData_In), .WD3_128_In(WD3_128_In),
    .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD), .Stall_Out(Stall_Out),
    .Busy_Out(Busy_Out), .Overrun_Out(Overrun_Out)
  );

  always #5 Clock = ~Clock;

  // {WE, WA, WD, Stall, Busy, Overrun}
  function automatic logic [40:0] pk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                     input logic st, input logic bs, input logic ov);
    return {we, wa, wd, st, bs, ov};
  endfunction

  task automatic chk(input string tag, input logic [40:0] exp);
    logic [40:0] obs;
    obs = {RF_WE, RF_WA, RF_WD, Stall_Out, Busy_Out, Overrun_Out};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic req(input logic rw, input logic l16, input logic [1:0] m2r, input logic [4:0] rd);
    RegWrite_In = rw;
    L16B_In     = l16;
    MemToReg_In = m2r;
    RegDest_In  = rd;
  endtask

  initial begin
    Reset = 1'b0;
    req(0, 0, 2'b00, 5'd0);
    ALUResult_In = 32'hA5A5A5A5;
    PC_In        = 32'h0;
    ReadData_In  = 32'h0;
    WD3_128_In   = '0;
    #2;
    chk("reset_low", pk(0, 0, 0, 0, 0, 0));
    step(); step();
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_after_reset", pk(0, 0, 0, 0, 0, 0));
    end

    // single 32-bit writes
    ReadData_In = 32'hDEADBEEF;
    req(1, 0, 2'b01, 5'd5);
    step(); chk("load_word", pk(1, 5'd5, 32'hDEADBEEF, 0, 0, 0));

    PC_In = 32'h00400010;
    req(1, 0, 2'b10, 5'd31);
    step(); chk("link_r31", pk(1, 5'd31, 32'h00400018, 0, 0, 0));

    req(1, 0, 2'b10, 5'd0);
    step(); chk("link_r0_guard", pk(0, 5'd0, 32'h00400018, 0, 0, 0));

    ALUResult_In = 32'h12345678;
    req(1, 0, 2'b00, 5'd10);
    step(); chk("alu_m00", pk(1, 5'd10, 32'h12345678, 0, 0, 0));

    ALUResult_In = 32'hCAFEF00D;
    req(1, 0, 2'b11, 5'd3);
    step(); chk("alu_m11", pk(1, 5'd3, 32'hCAFEF00D, 0, 0, 0));

    PC_In = 32'hFFFFFFFC;
    req(1, 0, 2'b10, 5'd4);
    step(); chk("link_wrap", pk(1, 5'd4, 32'h00000004, 0, 0, 0));

    WD3_128_In = 128'h44444444_33333333_22222222_11111111;
    req(0, 1, 2'b00, 5'd8);
    step(); chk("l16b_no_rw", pk(0, 0, 0, 0, 0, 0));

    // 128-bit burst to R8..R11
    req(1, 1, 2'b01, 5'd8);
    step(); chk("burst8_w0", pk(1, 5'd8,  32'h11111111, 1, 1, 0));
    req(0, 0, 2'b00, 5'd0);
    WD3_128_In = '0;
    step(); chk("burst8_w1", pk(1, 5'd9,  32'h22222222, 1, 1, 0));
    step(); chk("burst8_w2", pk(1, 5'd10, 32'h33333333, 1, 1, 0));
    step(); chk("burst8_w3", pk(1, 5'd11, 32'h44444444, 0, 1, 0));
    step(); chk("burst8_done", pk(0, 0, 0, 0, 0, 0));

    // first cycle after word 3 accepts a new request
    ReadData_In = 32'h0BADF00D;
    req(1, 0, 2'b01, 5'd6);
    step(); chk("after_burst", pk(1, 5'd6, 32'h0BADF00D, 0, 0, 0));

    // wrapping burst with overrun during the burst
    WD3_128_In = 128'h00000004_00000003_00000002_00000001;
    req(1, 1, 2'b00, 5'd30);
    step(); chk("burst30_w0", pk(1, 5'd30, 32'h1, 1, 1, 0));
    WD3_128_In = '0;
    req(1, 0, 2'b00, 5'd3);
    step(); chk("burst30_w1_ovr", pk(1, 5'd31, 32'h2, 1, 1, 1));
    req(0, 0, 2'b00, 5'd0);
    step(); chk("burst30_w2_r0", pk(0, 5'd0, 32'h3, 1, 1, 1));
    step(); chk("burst30_w3", pk(1, 5'd1, 32'h4, 0, 1, 1));
    req(1, 0, 2'b00, 5'd7);
    step(); chk("req_on_w3_ignored", pk(0, 0, 0, 0, 0, 1));
    req(0, 0, 2'b00, 5'd0);
    step(); chk("overrun_sticky", pk(0, 0, 0, 0, 0, 1));

    // reset asserted while the second burst word is on the port
    WD3_128_In = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    req(1, 1, 2'b00, 5'd12);
    step(); chk("burst12_w0", pk(1, 5'd12, 32'hAAAAAAAA, 1, 1, 1));
    req(0, 0, 2'b00, 5'd0);
    step(); chk("burst12_w1", pk(1, 5'd13, 32'hBBBBBBBB, 1, 1, 1));
    Reset = 1'b0;
    #1;
    chk("midburst_reset", pk(0, 0, 0, 0, 0, 0));
    #1;
    Reset = 1'b1;
    ReadData_In = 32'h00000055;
    req(1, 0, 2'b01, 5'd7);
    step(); chk("post_reset_req", pk(1, 5'd7, 32'h55, 0, 0, 0));
    req(0, 0, 2'b00, 5'd0);
    step(); chk("burst_dropped", pk(0, 0, 0, 0, 0, 0));
    step(); chk("still_idle", pk(0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
